// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared keyboard code constants and FSM state encoding
//
// Imported by kbd_event_ctrl and the keyboard wrapper so both agree on codes.
package kbd_pkg;

  localparam int CODE_W = 5;

  // Letter press codes produced by the wrapper.
  localparam logic [CODE_W-1:0] LTR_MIN    = 5'd1;
  localparam logic [CODE_W-1:0] LTR_MAX    = 5'd18;

  // Status / control codes.
  localparam logic [CODE_W-1:0] CODE_BAT   = 5'd20;
  localparam logic [CODE_W-1:0] CODE_BREAK = 5'd21;

  // The wrapper's "invalid/unmapped" code is 32. It has no bit 5 on the
  // 5-bit code bus, so it arrives as 0; that is the value the filter and
  // last-accepted register use. It also matches the empty key_letter value.
  localparam int                CODE_INVALID_RAW = 32;
  localparam logic [CODE_W-1:0] CODE_INVALID     = CODE_W'(CODE_INVALID_RAW);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BREAK = 1'b1
  } kbd_state_e;

  function automatic logic is_letter(input logic [CODE_W-1:0] code);
    return (code >= LTR_MIN) && (code <= LTR_MAX);
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// rtl/kbd_event_fifo.sv - first-word fall-through event queue
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (empties the queue)
//   push_i/data_i : enqueue request and payload
//   pop_i         : dequeue the head (ignored while empty)
//   valid_o       : queue not empty; data_o holds the head (0 when empty)
//   full_o        : queue holds DEPTH entries
//   drop_o        : push refused because full with no pop this cycle
module kbd_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty  = (wr_q == rd_q);
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  always_comb begin
    do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    do_push = push_i && (!full_o || do_pop);
    drop_o  = push_i && full_o && !do_pop;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem[rd_q[AW-1:0]];

endmodule

// File: rtl/kbd_event_ctrl.sv
// rtl/kbd_event_ctrl.sv - keyboard code filter, press/break sequencer and event queue
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   letter_i      : level code from the keyboard wrapper
//   key_valid_o   : a press event is at the queue head
//   key_letter_o  : head letter (1..18), 0 when empty
//   key_ready_i   : consumer takes the head this cycle
//   overflow_o    : sticky, a press was dropped on a full queue
//   ovf_clr_i     : clears overflow_o (a coincident drop wins)
//   bat_ok_o      : sticky, keyboard self-test pass seen since reset
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int BREAK_TIMEOUT = 200000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CODE_W-1:0] letter_i,
  output logic              key_valid_o,
  output logic [CODE_W-1:0] key_letter_o,
  input  logic              key_ready_i,
  output logic              overflow_o,
  input  logic              ovf_clr_i,
  output logic              bat_ok_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = (BREAK_TIMEOUT > 1) ? $clog2(BREAK_TIMEOUT) : 1;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(BREAK_TIMEOUT - 1);

  // Stability filter state.
  logic [CODE_W-1:0] samp_q, samp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0] last_q, last_d;
  logic              acc_vld_q, acc_vld_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;

  // Sequencer state.
  kbd_state_e        state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              ovf_q, ovf_d;
  logic              bat_q, bat_d;
  logic              push;

  // Queue interface.
  logic              fifo_valid;
  logic [CODE_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_drop;
  logic              pop;

  // cnt_d is the run length of identical samples including the one taken at
  // this edge; a value is accepted on the edge its run reaches STABLE_CYCLES.
  always_comb begin
    samp_d = letter_i;
    if (letter_i == samp_q) begin
      cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = CW'(1);
    end
    acc_vld_d  = (cnt_d == STABLE_C) && (letter_i != last_q);
    acc_code_d = acc_vld_d ? letter_i : acc_code_q;
    last_d     = acc_vld_d ? letter_i : last_q;
  end

  // The sequencer acts on the registered acceptance, one edge after the filter.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    bat_d   = bat_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (acc_vld_q) begin
          if (is_letter(acc_code_q)) begin
            push = 1'b1;
          end else if (acc_code_q == CODE_BREAK) begin
            state_d = ST_BREAK;
            tmo_d   = '0;
          end else if (acc_code_q == CODE_BAT) begin
            bat_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (acc_vld_q) begin
          // A repeated break prefix restarts the wait; anything else is the
          // released key and is swallowed.
          if (acc_code_q == CODE_BREAK) begin
            tmo_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop = key_ready_i && fifo_valid;
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      samp_q     <= CODE_INVALID;
      cnt_q      <= '0;
      last_q     <= CODE_INVALID;
      acc_vld_q  <= 1'b0;
      acc_code_q <= CODE_INVALID;
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      ovf_q      <= 1'b0;
      bat_q      <= 1'b0;
    end else begin
      samp_q     <= samp_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      acc_vld_q  <= acc_vld_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
      bat_q      <= bat_d;
    end
  end

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (acc_code_q),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop)
  );

  assign key_valid_o  = fifo_valid;
  assign key_letter_o = fifo_data;
  assign overflow_o   = ovf_q;
  assign bat_ok_o     = bat_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb/tb_kbd_event_ctrl.sv - directed self-checking bench for kbd_event_ctrl
module tb_kbd_event_ctrl;

  localparam int BT = 20;
  // Wrapper code 32 as it appears on the 5-bit bus.
  localparam logic [4:0] L_INV = 5'd0;
  localparam logic [4:0] L_BAT = 5'd20;
  localparam logic [4:0] L_BRK = 5'd21;

  logic       clk;
  logic       rst;
  logic [4:0] letter;
  logic       key_ready;
  logic       ovf_clr;
  logic       key_valid;
  logic [4:0] key_letter;
  logic       overflow;
  logic       bat_ok;

  int total = 0;
  int bad   = 0;

  kbd_event_ctrl #(
    .FIFO_DEPTH    (4),
    .STABLE_CYCLES (2),
    .BREAK_TIMEOUT (BT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .letter_i     (letter),
    .key_valid_o  (key_valid),
    .key_letter_o (key_letter),
    .key_ready_i  (key_ready),
    .overflow_o   (overflow),
    .ovf_clr_i    (ovf_clr),
    .bat_ok_o     (bat_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] code);
    letter = code;
    tick(3);
  endtask

  task automatic pop_expect(input string tag, input logic [4:0] exp);
    check({tag, "_valid"}, 32'(key_valid), 32'd1);
    check({tag, "_letter"}, 32'(key_letter), 32'(exp));
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    letter    = L_INV;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    check("rst_valid",  32'(key_valid),  32'd0);
    check("rst_letter", 32'(key_letter), 32'd0);
    check("rst_ovf",    32'(overflow),   32'd0);
    check("rst_bat",    32'(bat_ok),     32'd0);

    // Single press/release with latency: visible after the third edge.
    letter = 5'd1;
    tick(2);
    check("lat_early", 32'(key_valid), 32'd0);
    tick(1);
    check("lat_valid",  32'(key_valid),  32'd1);
    check("lat_letter", 32'(key_letter), 32'd1);
    tick(2);
    press(L_BRK);
    press(5'd1);
    pop_expect("single", 5'd1);
    check("single_once", 32'(key_valid), 32'd0);
    check("empty_letter", 32'(key_letter), 32'd0);
    // Back in IDLE: a new letter is a press.
    press(5'd3);
    pop_expect("idle_after_brk", 5'd3);

    // One-cycle glitch is never accepted.
    press(L_INV);
    letter = 5'd7;
    tick(1);
    letter = L_INV;
    tick(4);
    check("glitch", 32'(key_valid), 32'd0);

    // Overflow: fifth press dropped.
    press(5'd2);
    press(5'd3);
    press(5'd4);
    press(5'd5);
    check("full_no_ovf", 32'(overflow), 32'd0);
    press(5'd6);
    check("ovf_set", 32'(overflow), 32'd1);
    pop_expect("drain0", 5'd2);
    pop_expect("drain1", 5'd3);
    pop_expect("drain2", 5'd4);
    pop_expect("drain3", 5'd5);
    check("drain_empty", 32'(key_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full queue with push and pop on the same edge.
    press(5'd7);
    press(5'd8);
    press(5'd9);
    press(5'd10);
    letter = 5'd11;
    tick(2);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    check("pp_no_ovf", 32'(overflow), 32'd0);
    pop_expect("pp0", 5'd8);
    pop_expect("pp1", 5'd9);
    pop_expect("pp2", 5'd10);
    pop_expect("pp3", 5'd11);
    check("pp_empty", 32'(key_valid), 32'd0);

    // Break followed by a key is a release, no event.
    press(L_BRK);
    press(5'd12);
    check("release", 32'(key_valid), 32'd0);
    // Break timeout: next key after the timeout is a press.
    letter = L_BRK;
    tick(BT + 6);
    press(5'd9);
    pop_expect("tmo_press", 5'd9);

    // Self-test pass, then reset with events pending and overflow set.
    press(L_BAT);
    check("bat_set", 32'(bat_ok), 32'd1);
    press(5'd13);
    press(5'd14);
    press(5'd15);
    press(5'd16);
    press(5'd17);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    check("pre_rst_valid", 32'(key_valid), 32'd1);
    letter = L_INV;
    rst = 1'b1;
    tick(1);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_bat",   32'(bat_ok),    32'd0);
    check("mid_rst_ovf",   32'(overflow),  32'd0);
    rst = 1'b0;
    tick(4);
    check("post_rst_valid", 32'(key_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
